leaf_user_fifo: RTL and testbench
=================================

Name: leaf_user_fifo

Overview:
- Elastic buffer between one leaf_interface user-facing port (32-bit vld/ack stream, interface2user direction) and an HLS user kernel input using ap_fifo semantics (dout/empty_n/read).
- One instance per input port of a leaf shell, in the clk_user domain.
- Absorbs kernel stalls, so the interface is never held by combinational kernel logic.
- Registered occupancy bookkeeping.

Parameters:
- PAYLOAD_BITS, 32, data word width; matches the leaf_interface payload.
- ADDR_BITS, 5, log2 of storage depth; DEPTH = 2**ADDR_BITS.
- ALMOST_FULL_MARGIN, 2, free-slot threshold for almost_full.

Ports:
- clk_user  in  1  user clock; the single clock for the block.
- reset  in  1  synchronous, active-high reset.
- din_leaf_interface2user  in  PAYLOAD_BITS  word from leaf_interface.
- vld_interface2user  in  1  word valid.
- ack_user2interface  out  1  ready/accept to leaf_interface.
- fifo_dout  out  PAYLOAD_BITS  head word to kernel.
- fifo_empty_n  out  1  head word valid.
- fifo_read  in  1  kernel pop request.
- almost_full  out  1  free slots <= ALMOST_FULL_MARGIN.

Behaviour:
- Clocking and reset: one clock, clk_user. Reset is synchronous and active-high, named reset.
- Reset values: ack_user2interface=0, fifo_empty_n=0, almost_full=0. Pointers and count are 0. fifo_dout is don't-care while fifo_empty_n=0.
- Write handshake: a transfer occurs on a rising edge where vld_interface2user && ack_user2interface.
  - The word is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Read handshake: a pop occurs on a rising edge where fifo_read && fifo_empty_n.
  - rd_ptr increments modulo DEPTH.
  - fifo_read while fifo_empty_n=0 is ignored; no state change, no error.
- Counter: count is ADDR_BITS+1 bits wide, range 0..DEPTH.
  - count_next = count + wr - rd.
- Registered flags, all computed from count_next:
  - ack_user2interface <= (count_next != DEPTH)
  - fifo_empty_n <= (count_next != 0)
  - almost_full <= (DEPTH - count_next <= ALMOST_FULL_MARGIN)
  - No combinational path from fifo_read or vld_interface2user to any output except fifo_dout.
- fifo_dout: first-word-fall-through, asynchronous read of storage at rd_ptr (distributed RAM).
  - Valid whenever fifo_empty_n=1.
  - Stable until popped.
- Latency: a word written at edge t is visible (fifo_empty_n=1, fifo_dout=word) after edge t, i.e. cycle t+1.
- Full: ack_user2interface=0. A simultaneous pop at full does not raise ack in the same cycle; ack rises the following cycle.
- Empty with simultaneous write: the write is accepted and the read is ignored; count becomes 1.
- Simultaneous write and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0 with no data loss; ordering is strict FIFO.
- Reset mid-operation: all contents are discarded.
  - Outputs take their reset values on the edge where reset is high.
  - ack_user2interface returns to 1 on the first edge with reset low.
- Post-reset ordering: vld_interface2user asserted during reset is not accepted. The upstream holds data per the vld/ack protocol.

Optional Feature:
- Macro: LEAF_USER_FIFO_STATS_EN.
- When defined, adds output port max_occupancy [ADDR_BITS:0]: the high-water mark of count since reset, updated when count_next > max_occupancy, registered, reset to 0.
- Also adds output port overflow_attempt_cnt [15:0]: counts cycles with vld_interface2user=1 && ack_user2interface=0. Saturates at 16'hFFFF; reset to 0.
- When undefined, neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package leaf_pkg holds:
  - constant PAYLOAD_BITS_DEFAULT = 32
  - typedef payload_t (logic [PAYLOAD_BITS_DEFAULT-1:0])
  - function clog2-based depth helper, reused by the leaf shells
- One sub-module: leaf_user_fifo_mem, the simple dual-port distributed RAM (sync write, async read).
  - Keeps the storage inferable and separately swappable for BRAM.
- Pointer, count and flag logic stays in leaf_user_fifo.

Test Plan:
- Reset then single word: drive 32'hDEADBEEF with vld=1 one cycle after reset release.
  - ack is 0 during reset and 1 on the first edge after.
  - fifo_empty_n=1 and fifo_dout=32'hDEADBEEF one cycle after the accept.
  - read=1 gives fifo_empty_n=0 the next cycle.
- Fill to full, ADDR_BITS=5, no reads: write 0..31.
  - almost_full rises after count reaches 30.
  - ack falls after the 32nd accept.
  - A 33rd vld is held; with STATS_EN, overflow_attempt_cnt increments per held cycle.
- Pop at full: one read while full.
  - ack stays 0 that cycle and rises the next.
  - Word 0 is popped; the held word is accepted afterwards.
- Continuous streaming with vld=1 and read=1 for 100 cycles from count=1.
  - count stays 1 and pointers wrap at least 3 times.
  - Output sequence equals input sequence; with STATS_EN, max_occupancy=1 after the pre-fill.
- Empty corner: read=1 with empty_n=0 for 5 cycles, then write 32'h1.
  - No pop occurs; the word is accepted.
  - fifo_dout=32'h1 the next cycle, with no spurious underflow.
- Reset mid-stream at count=17: assert reset one cycle.
  - Next cycle: empty_n=0, almost_full=0, ack=0; count 0.
  - The first word written after reset is the first word read.

Source files
------------

// File: rtl/leaf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leaf_pkg
// Purpose  : Shared constants, payload type and depth helpers for leaf shells.
// Revision : 1.0 - initial release
// ============================================================================
package leaf_pkg;

  localparam int PAYLOAD_BITS_DEFAULT = 32;

  typedef logic [PAYLOAD_BITS_DEFAULT-1:0] payload_t;

  function automatic int unsigned depth_from_addr_bits(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  // Smallest address width covering a depth; never narrower than one bit.
  function automatic int unsigned addr_bits_for_depth(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_user_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : leaf_user_fifo_mem
// Purpose  : Simple dual-port distributed RAM, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_user_fifo_mem
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEFAULT,
  parameter int ADDR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [PAYLOAD_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [PAYLOAD_BITS-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/leaf_user_fifo.sv
`default_nettype none
// ============================================================================
// Module   : leaf_user_fifo
// Purpose  : FWFT elastic buffer from a vld/ack leaf stream to an ap_fifo kernel
//            input. Optional statistics ports under LEAF_USER_FIFO_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_user_fifo
  import leaf_pkg::*;
#(
  parameter int PAYLOAD_BITS       = PAYLOAD_BITS_DEFAULT,
  parameter int ADDR_BITS          = 5,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] din_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] fifo_dout,
  output logic                    fifo_empty_n,
  input  logic                    fifo_read,
  output logic                    almost_full
`ifdef LEAF_USER_FIFO_STATS_EN
  ,
  output logic [ADDR_BITS:0]      max_occupancy,
  output logic [15:0]             overflow_attempt_cnt
`endif
);

  localparam int unsigned DEPTH = depth_from_addr_bits(ADDR_BITS);
  localparam logic [ADDR_BITS:0] DEPTH_CNT  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] MARGIN_CNT = (ADDR_BITS+1)'(ALMOST_FULL_MARGIN);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   count_next;
  logic [ADDR_BITS:0]   free_next;
  logic                 wr_en;
  logic                 rd_en;

  // Handshakes qualify only on registered flags, keeping upstream/kernel paths short.
  assign wr_en = vld_interface2user && ack_user2interface;
  assign rd_en = fifo_read && fifo_empty_n;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign free_next = DEPTH_CNT - count_next;

  always_ff @(posedge clk_user) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      ack_user2interface <= 1'b0;
      fifo_empty_n       <= 1'b0;
      almost_full        <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count              <= count_next;
      ack_user2interface <= (count_next != DEPTH_CNT);
      fifo_empty_n       <= (count_next != '0);
      almost_full        <= (free_next <= MARGIN_CNT);
    end
  end

  leaf_user_fifo_mem #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .ADDR_BITS    (ADDR_BITS)
  ) u_mem (
    .clk   (clk_user),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (din_leaf_interface2user),
    .raddr (rd_ptr),
    .rdata (fifo_dout)
  );

`ifdef LEAF_USER_FIFO_STATS_EN
  always_ff @(posedge clk_user) begin
    if (reset) begin
      max_occupancy        <= '0;
      overflow_attempt_cnt <= '0;
    end else begin
      if (count_next > max_occupancy) begin
        max_occupancy <= count_next;
      end
      if (vld_interface2user && !ack_user2interface && (overflow_attempt_cnt != 16'hFFFF)) begin
        overflow_attempt_cnt <= overflow_attempt_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_leaf_user_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_user_fifo
// Purpose  : Self-checking bench for leaf_user_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_user_fifo;

  localparam int DEPTH  = 32;
  localparam int MARGIN = 2;

  logic        clk_user = 1'b0;
  logic        reset    = 1'b1;
  logic [31:0] din      = '0;
  logic        vld      = 1'b0;
  logic        ack;
  logic [31:0] dout;
  logic        empty_n;
  logic        fifo_read = 1'b0;
  logic        almost_full;
`ifdef LEAF_USER_FIFO_STATS_EN
  logic [5:0]  max_occupancy;
  logic [15:0] overflow_attempt_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_user = ~clk_user;

  leaf_user_fifo #(
    .PAYLOAD_BITS       (32),
    .ADDR_BITS          (5),
    .ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clk_user                (clk_user),
    .reset                   (reset),
    .din_leaf_interface2user (din),
    .vld_interface2user      (vld),
    .ack_user2interface      (ack),
    .fifo_dout               (dout),
    .fifo_empty_n            (empty_n),
    .fifo_read               (fifo_read),
    .almost_full             (almost_full)
`ifdef LEAF_USER_FIFO_STATS_EN
    ,
    .max_occupancy           (max_occupancy),
    .overflow_attempt_cnt    (overflow_attempt_cnt)
`endif
  );

  // Reference model: a queue of stored words; flags are pure functions of its size.
  logic [31:0] q[$];
  bit          m_rst = 1'b1;
  int          m_max = 0;
  int          m_ovf = 0;

  function automatic bit m_ack();
    return !m_rst && (q.size() != DEPTH);
  endfunction

  function automatic bit m_empty_n();
    return !m_rst && (q.size() != 0);
  endfunction

  function automatic bit m_af();
    return !m_rst && ((DEPTH - q.size()) <= MARGIN);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ack", {31'd0, ack}, {31'd0, m_ack()});
    chk("empty_n", {31'd0, empty_n}, {31'd0, m_empty_n()});
    chk("almost_full", {31'd0, almost_full}, {31'd0, m_af()});
    if (m_empty_n()) chk("dout", dout, q[0]);
`ifdef LEAF_USER_FIFO_STATS_EN
    chk("max_occupancy", {26'd0, max_occupancy}, 32'(m_max));
    chk("overflow_attempt_cnt", {16'd0, overflow_attempt_cnt}, 32'(m_ovf));
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic rd);
    bit pre_ack;
    bit pre_ne;
    reset     = r;
    vld       = v;
    din       = d;
    fifo_read = rd;
    @(posedge clk_user);
    pre_ack = m_ack();
    pre_ne  = m_empty_n();
    if (r) begin
      q.delete();
      m_rst = 1'b1;
      m_max = 0;
      m_ovf = 0;
    end else begin
      if (v && !pre_ack && m_ovf != 16'hFFFF) m_ovf++;
      if (rd && pre_ne) void'(q.pop_front());
      if (v && pre_ack) q.push_back(d);
      m_rst = 1'b0;
      if (q.size() > m_max) m_max = q.size();
    end
    #1;
    check_all();
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        rd;
    logic        e_ack;
    logic        e_ne;
    logic        e_af;
    logic        chk_d;
    logic [31:0] e_d;
  } vec_t;

  vec_t tbl[11];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset, single word, empty-read corner, written as fixed expectations.
    tbl[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 4; i < 9; i++)
      tbl[i] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h1,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d_ack", i), {31'd0, ack}, {31'd0, tbl[i].e_ack});
      chk($sformatf("vec%0d_empty_n", i), {31'd0, empty_n}, {31'd0, tbl[i].e_ne});
      chk($sformatf("vec%0d_af", i), {31'd0, almost_full}, {31'd0, tbl[i].e_af});
      if (tbl[i].chk_d) chk($sformatf("vec%0d_dout", i), dout, tbl[i].e_d);
    end

    // Fill to full with words 0..31, no reads.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b0);
      chk("fill_af", {31'd0, almost_full}, {31'd0, (i + 1 >= 30)});
      chk("fill_ack", {31'd0, ack}, {31'd0, (i + 1 < DEPTH)});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd32, 1'b0);
      chk("held_ack", {31'd0, ack}, 32'd0);
`ifdef LEAF_USER_FIFO_STATS_EN
      chk("held_ovf", {16'd0, overflow_attempt_cnt}, 32'(i + 1));
`endif
    end
    chk("full_head", dout, 32'd0);

    // Pop at full: ack rises only after the pop edge, held word then accepted.
    step(1'b0, 1'b1, 32'd32, 1'b1);
    chk("popfull_ack", {31'd0, ack}, 32'd1);
    chk("popfull_head", dout, 32'd1);
    step(1'b0, 1'b1, 32'd32, 1'b0);
    chk("popfull_refull", {31'd0, ack}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_empty", {31'd0, empty_n}, 32'd0);

    // Streaming at count=1 for 100 cycles, pointers wrap several times.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hA0000000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, $urandom, 1'b1);
      chk("stream_ne", {31'd0, empty_n}, 32'd1);
      chk("stream_ack", {31'd0, ack}, 32'd1);
    end
`ifdef LEAF_USER_FIFO_STATS_EN
    chk("stream_max_occ", {26'd0, max_occupancy}, 32'd1);
`endif

    // Reset mid-stream at count=17.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 32'hBAD0BAD0, 1'b0);
    chk("midrst_ack", {31'd0, ack}, 32'd0);
    chk("midrst_ne", {31'd0, empty_n}, 32'd0);
    chk("midrst_af", {31'd0, almost_full}, 32'd0);
    step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
    step(1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
    chk("postrst_first", dout, 32'hA5A5A5A5);

    // Randomized traffic with varying read pressure and rare resets.
    for (int i = 0; i < 1200; i++) begin
      int rd_pct;
      rd_pct = (i / 200) % 2 == 0 ? 25 : 75;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < 70), $urandom,
           ($urandom_range(0, 99) < rd_pct));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
